aes_inv_sub_bytes_seq: RTL and testbench
========================================

Name: aes_inv_sub_bytes_seq

Overview:
- Sequential InvSubBytes engine for the AES-128 decrypt path; the inverse of the combinational forward byte substitution used on the encrypt side.
- Accepts a 16-byte AES state byte-serially over a valid/ready stream and computes InvSbox on each byte. The GF(2^8) inverse is computed by iterative square-and-multiply rather than a ROM.
- Streams the 16 result bytes out in the same order they were received. Sits between the decrypt datapath input (InvShiftRows result) and AddRoundKey.

Parameters:
- NUM_BYTES, 16, bytes per frame (AES state); must be ≥1; counters are $clog2(NUM_BYTES) bits wide, minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  in_byte carries a valid state byte
- in_ready  out  1  engine can accept a byte this cycle
- in_byte  in  8  input state byte, column-major order
- out_valid  out  1  out_byte is valid
- out_ready  in  1  downstream accepts out_byte this cycle
- out_byte  out  8  InvSbox result byte
- busy  out  1  high whenever not in LOAD

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State becomes LOAD; all counters go to 0.
  - in_ready=1 in the cycle after reset; out_valid=0, out_byte=0, busy=0.
  - Buffer contents are don't-care.
  - Reset mid-frame aborts the frame; no partial output is produced.
- Storage: 16x8 buffer; each entry is written in place with its result.
- State LOAD:
  - in_ready=1.
  - On in_valid&in_ready: buf[wr_idx] <= InvAffine(in_byte), wr_idx++.
  - InvAffine(s) = ROTL(s,1) ^ ROTL(s,3) ^ ROTL(s,6) ^ 0x05.
  - When the byte at index NUM_BYTES-1 is accepted: go to COMPUTE, idx=0, step=0.
- State COMPUTE:
  - in_ready=0. Each byte takes exactly 8 cycles.
  - a = buf[idx]; r is initialised to 0x01 when step=0.
  - Each cycle: r <= (r·r)·a if bit (7-step) of 0xFE is 1, else r <= r·r.
  - Multiply is in GF(2^8) with polynomial 0x11B; two combinational multipliers are used.
  - At step=7: buf[idx] <= result, idx++, step=0. The result equals a^254, so 0 maps to 0 with no special case.
  - After the last byte: go to DRAIN, rd_idx=0. Total COMPUTE time is 8·NUM_BYTES cycles (128 for the default).
- State DRAIN:
  - out_valid=1 and out_byte=buf[rd_idx] (registered).
  - out_byte/out_valid hold stable while out_ready=0.
  - On out_valid&out_ready: rd_idx++.
  - On the last transfer: out_valid falls in the next cycle, state becomes LOAD, in_ready=1 in that same next cycle. No back-to-back overlap between frames.
- busy=1 in COMPUTE and DRAIN.
- in_valid asserted outside LOAD is ignored; no byte is consumed.
- Ordering: output byte k corresponds to input byte k.
- Index wrap: idx/wr_idx/rd_idx compare against NUM_BYTES-1, never rely on natural wrap.

Optional Feature:
- Macro INV_SBOX_ROM_EN.
- Defined:
  - COMPUTE uses a 256-entry combinational InvSbox table applied to the raw input byte; InvAffine is not applied at load.
  - 1 cycle per byte, so COMPUTE lasts NUM_BYTES cycles.
  - Ports, handshakes and output values are identical to the undefined build.
- Undefined (default): iterative 8-cycle path as described in Behaviour.

Test Plan:
- Single frame of known values:
  - Send 0x63,0x7C,0xED,0x00,0x16 then 0x63 repeated for the remaining bytes, with out_ready=1.
  - Required outputs: 0x00,0x01,0x53,0x52,0xFF, then 0x00 repeated.
  - out_valid rises exactly 8·16+1 cycles after the 16th input handshake (17 with ROM_EN).
- Full-range inverse check:
  - Run 16 frames covering inputs 0x00..0xFF.
  - Each output must equal the reference InvSbox. Sbox(out) must equal the input.
- Backpressure:
  - Toggle out_ready pseudo-randomly during DRAIN.
  - out_byte must stay stable while stalled; exactly 16 transfers in order; no duplicates or drops.
- Input gaps and ignored input:
  - Insert random in_valid gaps in LOAD, and assert in_valid with junk bytes during COMPUTE/DRAIN.
  - Junk bytes are never accepted; in_ready=0 and busy=1 throughout COMPUTE/DRAIN.
- Reset mid-operation:
  - Assert rst_n=0 for 1 cycle during COMPUTE byte 5 and again during DRAIN byte 9.
  - Next cycle: out_valid=0, in_ready=1, busy=0. The following full frame produces correct results.
- Back-to-back frames:
  - Send two frames with in_valid held high.
  - The second frame is accepted only after the first DRAIN completes; both outputs are correct.

Source files
------------

// File: rtl/aes_inv_sub_bytes_seq.sv
// Byte-serial AES InvSubBytes engine: load a state, invert each byte in place, stream it back out.
// Define INV_SBOX_ROM_EN to swap the 8-cycle square-and-multiply inverse for a one-cycle InvSbox table.
module aes_inv_sub_bytes_seq #(
  parameter int NUM_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       busy
);

  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ s;
      s = s[7] ? ({s[6:0], 1'b0} ^ 8'h1B) : {s[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] idx;
  logic [CW-1:0] rd_idx;
  logic [CW-1:0] next_rd;
  logic [7:0]    buf_mem [NUM_BYTES];

  logic          accept;
  logic          byte_done;
  logic [7:0]    a;
  logic [7:0]    load_data;
  logic [7:0]    result;
  logic          wr_en;
  logic [CW-1:0] wr_addr;
  logic [7:0]    wr_data;

  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD);
  assign accept   = in_valid && in_ready;
  assign a        = buf_mem[idx];
  assign next_rd  = rd_idx + CW'(1);

`ifndef INV_SBOX_ROM_EN
  // a^254 by left-to-right square-and-multiply over the exponent bits of 0xFE
  localparam logic [7:0] EXP = 8'hFE;

  logic [2:0] step;
  logic [7:0] r_reg;
  logic [7:0] r_cur;
  logic [7:0] r_sq;
  logic [7:0] r_mul;
  logic [7:0] r_next;

  always_comb begin
    r_cur  = (step == 3'd0) ? 8'h01 : r_reg;
    r_sq   = gmul(r_cur, r_cur);
    r_mul  = gmul(r_sq, a);
    r_next = EXP[3'd7 - step] ? r_mul : r_sq;
  end

  assign byte_done = (state == COMPUTE) && (step == 3'd7);
  assign load_data = inv_affine(in_byte);
  assign result    = r_next;
`else
  // Table built at elaboration from the same affine + inverse definition
  function automatic logic [2047:0] build_inv_sbox();
    logic [2047:0] t;
    logic [7:0]    x;
    logic [7:0]    r;
    t = '0;
    for (int s = 0; s < 256; s++) begin
      x = inv_affine(8'(s));
      r = 8'h01;
      for (int k = 7; k >= 0; k--) begin
        r = gmul(r, r);
        if (k != 0) r = gmul(r, x);
      end
      t[s*8 +: 8] = r;
    end
    return t;
  endfunction

  localparam logic [2047:0] INV_SBOX_TABLE = build_inv_sbox();

  assign byte_done = (state == COMPUTE);
  assign load_data = in_byte;
  assign result    = INV_SBOX_TABLE[{a, 3'b000} +: 8];
`endif

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_idx;
    wr_data = load_data;
    if (accept) begin
      wr_en = 1'b1;
    end else if (byte_done) begin
      wr_en   = 1'b1;
      wr_addr = idx;
      wr_data = result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) buf_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      wr_idx    <= '0;
      idx       <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
`ifndef INV_SBOX_ROM_EN
      step      <= 3'd0;
      r_reg     <= 8'h00;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (wr_idx == LAST) begin
              wr_idx <= '0;
              idx    <= '0;
              state  <= COMPUTE;
`ifndef INV_SBOX_ROM_EN
              step   <= 3'd0;
`endif
            end else begin
              wr_idx <= wr_idx + CW'(1);
            end
          end
        end
        COMPUTE: begin
`ifndef INV_SBOX_ROM_EN
          r_reg <= r_next;
          step  <= byte_done ? 3'd0 : step + 3'd1;
`endif
          if (byte_done) begin
            if (idx == LAST) begin
              idx    <= '0;
              rd_idx <= '0;
              state  <= DRAIN;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        DRAIN: begin
          // First DRAIN cycle primes the output register; afterwards it advances per transfer
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_byte  <= buf_mem[rd_idx];
          end else if (out_ready) begin
            if (rd_idx == LAST) begin
              out_valid <= 1'b0;
              rd_idx    <= '0;
              state     <= LOAD;
            end else begin
              rd_idx   <= next_rd;
              out_byte <= buf_mem[next_rd];
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Directed bench for aes_inv_sub_bytes_seq: known vectors, full 0x00..0xFF sweep against the
// standard InvSbox/Sbox tables, backpressure, ignored input, mid-frame reset and back-to-back frames.
module tb_aes_inv_sub_bytes_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_byte = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_byte;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] vec [16];
  logic [7:0] got [16];

`ifdef INV_SBOX_ROM_EN
  localparam int LAT      = 17;
  localparam int RST_WAIT = 5;
`else
  localparam int LAT      = 129;
  localparam int RST_WAIT = 42;
`endif

  localparam logic [2047:0] INV_SBOX_P = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [2047:0] SBOX_P = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] EXP1_P = 128'h00015352ff0000000000000000000000;

  aes_inv_sub_bytes_seq #(.NUM_BYTES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] inv_ref(input logic [7:0] b);
    return INV_SBOX_P[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    return SBOX_P[(255 - int'(b)) * 8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drives vec[] byte by byte; optional idle gaps; hold leaves in_valid high afterwards
  task automatic push_frame(input bit gaps, input bit hold);
    int n;
    for (int k = 0; k < 16; k++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_byte  = 8'h5A;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_byte  = vec[k];
      n = 0;
      while (!in_ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    if (hold) in_byte = 8'hA5;
    else in_valid = 1'b0;
  endtask

  // Collects n output bytes into got[]; checks stall stability and that input is blocked meanwhile
  task automatic drain(input bit stall, input int n);
    int         k = 0;
    int         guard = 0;
    logic [7:0] held = 8'h00;
    bit         held_v = 1'b0;
    while (k < n && guard < 3000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("busy_no_ready", 32'({busy, in_ready}), 32'b10);
      if (held_v) chk("stall_hold", 32'({out_valid, out_byte}), 32'({1'b1, held}));
      held_v = 1'b0;
      if (out_valid && out_ready) begin
        got[k] = out_byte;
        k++;
      end else if (out_valid) begin
        held   = out_byte;
        held_v = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    if (k < n) chk("drain_timeout", 32'(k), 32'(n));
    if (n == 16) chk("frame_end", 32'({out_valid, in_ready, busy}), 32'b010);
    out_ready = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_inv"}, 32'(got[k]), 32'(inv_ref(vec[k])));
      chk({tag, "_fwd"}, 32'(sbox_ref(got[k])), 32'(vec[k]));
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("after_reset", 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  initial begin
    int cnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_flags", 32'({out_valid, in_ready, busy}), 32'b010);
    chk("reset_out_byte", 32'(out_byte), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Known vectors and latency
    for (int k = 0; k < 16; k++) vec[k] = 8'h63;
    vec[1] = 8'h7C;
    vec[2] = 8'hED;
    vec[3] = 8'h00;
    vec[4] = 8'h16;
    push_frame(1'b0, 1'b0);
    chk("compute_flags", 32'({busy, in_ready, out_valid}), 32'b100);
    cnt = 0;
    while (!out_valid && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(LAT));
    drain(1'b0, 16);
    for (int k = 0; k < 16; k++) chk("known", 32'(got[k]), 32'(EXP1_P[(15 - k) * 8 +: 8]));
    $display("frame known: out[0..4]=%h %h %h %h %h", got[0], got[1], got[2], got[3], got[4]);

    // Full 0x00..0xFF sweep with gaps, stalls and junk input mixed in
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < 16; k++) vec[k] = 8'(f * 16 + k);
      push_frame(f[0], (f % 4) == 3);
      drain(f[1], 16);
      in_valid = 1'b0;
      check_frame("sweep");
      $display("frame sweep %0d: in=%h..%h out=%h..%h", f, vec[0], vec[15], got[0], got[15]);
    end

    // Reset during COMPUTE byte 5, then during DRAIN byte 9
    for (int k = 0; k < 16; k++) vec[k] = 8'(k * 17 + 3);
    push_frame(1'b0, 1'b0);
    repeat (RST_WAIT) @(negedge clk);
    pulse_reset();
    push_frame(1'b0, 1'b0);
    drain(1'b0, 9);
    pulse_reset();
    push_frame(1'b1, 1'b0);
    drain(1'b1, 16);
    check_frame("post_reset");
    $display("frame post_reset: out[0]=%h out[15]=%h", got[0], got[15]);

    // Back-to-back with in_valid held high across the boundary
    for (int k = 0; k < 16; k++) vec[k] = 8'(8'hF0 - k * 5);
    push_frame(1'b0, 1'b1);
    in_byte = 8'h3C;
    drain(1'b0, 16);
    check_frame("b2b_a");
    $display("frame b2b_a: out[0]=%h out[15]=%h", got[0], got[15]);
    for (int k = 0; k < 16; k++) vec[k] = 8'(8'h3C + k * 7);
    push_frame(1'b0, 1'b0);
    drain(1'b0, 16);
    check_frame("b2b_b");
    $display("frame b2b_b: out[0]=%h out[15]=%h", got[0], got[15]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
